// File: rtl/unified_mem_arbiter.sv
`timescale 1ns/1ps
// ============================================================================
// unified_mem_arbiter
//
// Lets the instruction-fetch port and the load/store port of the core share a
// single-port unified memory. Requests are arbitrated round-robin. Only one
// transaction is outstanding at a time, and a latency counter tracks when its
// response arrives. Read data is routed back to whichever requester owns the
// transaction and is held in that requester's rdata register.
//
// Ports
//   clk, reset            : clock (rising edge) and synchronous active-high reset
//   if_req/if_addr        : fetch request, held until if_gnt
//   if_gnt                : fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata    : fetch response pulse / fetch data (held)
//   d_req/d_we/d_addr/
//   d_wdata/d_be          : load/store request, held until d_gnt
//   d_gnt                 : data request accepted this cycle (combinational)
//   d_rvalid/d_rdata      : load data or store acknowledge pulse / load data (held)
//   mem_en/mem_we/mem_be/
//   mem_addr/mem_wdata    : memory macro command (driven in the issue cycle)
//   mem_rdata             : memory read data, valid MEM_LAT cycles after issue
// ============================================================================
module unified_mem_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    localparam logic [2:0] LAT_CNT = 3'(MEM_LAT);

    state_t            state_reg;
    logic [2:0]        cnt_reg;          // counts down to 1; 1 marks the response cycle
    logic              owner_d_reg;      // outstanding transaction belongs to the data port
    logic              owner_store_reg;  // outstanding transaction is a store
    logic              last_d_reg;       // data port won the most recent issue
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;

    logic resp;
    logic slot;
    logic pick_d;
    logic issue;

    // Reset suppresses both the response and any new grant in the same cycle,
    // so an in-flight transaction is silently dropped.
    always_comb begin
        resp   = !reset && (state_reg == ST_WAIT) && (cnt_reg == 3'd1);
        slot   = !reset && ((state_reg == ST_IDLE) || resp);
        // On a conflict the port that did not win last time goes first.
        pick_d = d_req && (!if_req || !last_d_reg);
        issue  = slot && (if_req || d_req);
    end

    assign if_gnt    = issue && !pick_d;
    assign d_gnt     = issue && pick_d;
    assign mem_en    = issue;
    assign mem_we    = issue && pick_d && d_we;
    assign mem_be    = !issue ? 4'h0 : (mem_we ? d_be : 4'hF);
    assign mem_addr  = !issue ? addr_reg : (pick_d ? d_addr : if_addr);
    assign mem_wdata = (issue && pick_d) ? d_wdata : wdata_reg;

    assign if_rvalid = resp && !owner_d_reg;
    assign d_rvalid  = resp && owner_d_reg;
    // Read data is forwarded in the response cycle and then held in the
    // owner's register; a store acknowledge leaves d_rdata untouched.
    assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_reg;
    assign d_rdata   = (d_rvalid && !owner_store_reg) ? mem_rdata : d_rdata_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= 3'd0;
            owner_d_reg     <= 1'b0;
            owner_store_reg <= 1'b0;
            last_d_reg      <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            if_rdata_reg    <= '0;
            d_rdata_reg     <= '0;
        end else begin
            addr_reg     <= mem_addr;
            wdata_reg    <= mem_wdata;
            if_rdata_reg <= if_rdata;
            d_rdata_reg  <= d_rdata;
            if (issue) begin
                // A new issue may overlap the response cycle of the previous one.
                state_reg       <= ST_WAIT;
                cnt_reg         <= LAT_CNT;
                owner_d_reg     <= pick_d;
                owner_store_reg <= pick_d && d_we;
                last_d_reg      <= pick_d;
            end else if (resp) begin
                state_reg <= ST_IDLE;
                cnt_reg   <= 3'd0;
            end else if (state_reg == ST_WAIT) begin
                cnt_reg <= cnt_reg - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
`timescale 1ns/1ps
// Testbench for unified_mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3),
// each with a memory-macro stand-in, directed and random requesters, an issue
// model that predicts grants/commands from the arbitration rules, and a
// response monitor that pops expected responses from per-port queues.
module tb_unified_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
        bit          store;
    } exp_t;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp, input int lat);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lat%0d %s cycle %0d: got %h expected %h", lat, name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int a);
        return 32'h1357_0000 ^ (32'(a) * 32'h0001_0421);
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? 1 : 3;

        logic        reset, if_req, if_gnt, if_rvalid;
        logic        d_req, d_we, d_gnt, d_rvalid, mem_en, mem_we;
        logic [11:0] if_addr, d_addr, mem_addr;
        logic [31:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
        logic [3:0]  d_be, mem_be;
        logic        mem_init;
        bit          done = 1'b0;

        unified_mem_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(LAT)) dut (
            .clk(clk), .reset(reset),
            .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
            .if_rvalid(if_rvalid), .if_rdata(if_rdata),
            .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
            .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
            .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
        );

        // Memory macro stand-in: byte-enabled writes, reads return after LAT
        // cycles; junk appears on mem_rdata whenever no read is due.
        logic [31:0] mem  [0:4095];
        logic [31:0] pipe [0:LAT-1];
        assign mem_rdata = pipe[LAT-1];

        always @(posedge clk) begin
            if (mem_init) begin
                for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
            end else if (mem_en && mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : $urandom;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end

        exp_t        q_if[$];
        exp_t        q_d[$];
        logic [31:0] ref_mem [0:4095];

        // Issue model: a transaction started in cycle c occupies the memory
        // until cycle c+LAT, which is itself a legal issue cycle.
        initial begin
            int          busy_until;
            bit          last_d;
            logic [11:0] last_addr;
            bit          slot, issue, w_d;
            logic [3:0]  be;
            logic [11:0] a;
            exp_t        e;
            busy_until = -1;
            last_d     = 1'b0;
            last_addr  = '0;
            for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
            forever begin
                @(negedge clk);
                if (reset) begin
                    check("gnt_during_reset", {if_gnt, d_gnt, mem_en}, 0, LAT);
                    busy_until = -1;
                    last_d     = 1'b0;
                    last_addr  = '0;
                    q_if.delete();
                    q_d.delete();
                end else begin
                    slot  = (busy_until < 0) || (cyc >= busy_until);
                    issue = slot && (if_req || d_req);
                    w_d   = d_req && (!if_req || !last_d);
                    be    = !issue ? 4'h0 : ((w_d && d_we) ? d_be : 4'hF);
                    a     = !issue ? last_addr : (w_d ? d_addr : if_addr);
                    check("issue_ctl", {if_gnt, d_gnt, mem_en, mem_we, mem_be},
                          {issue && !w_d, issue && w_d, issue, issue && w_d && d_we, be}, LAT);
                    check("mem_addr", mem_addr, a, LAT);
                    if (issue) begin
                        e.due   = cyc + LAT;
                        e.store = w_d && d_we;
                        e.data  = ref_mem[a];
                        if (e.store) begin
                            check("mem_wdata", mem_wdata, d_wdata, LAT);
                            for (int b = 0; b < 4; b++)
                                if (d_be[b]) ref_mem[a][8*b +: 8] = d_wdata[8*b +: 8];
                        end
                        if (w_d) q_d.push_back(e);
                        else     q_if.push_back(e);
                        last_d     = w_d;
                        busy_until = cyc + LAT;
                        last_addr  = a;
                    end
                end
            end
        end

        // Response monitor
        initial begin
            logic [31:0] held_if, held_d;
            exp_t        e;
            held_if = '0;
            held_d  = '0;
            forever begin
                @(negedge clk);
                if (reset) begin
                    check("rvalid_during_reset", {if_rvalid, d_rvalid}, 0, LAT);
                    held_if = '0;
                    held_d  = '0;
                end else begin
                    if (if_rvalid) begin
                        if (q_if.size() == 0) check("if_rvalid_unexpected", 1, 0, LAT);
                        else begin
                            e = q_if.pop_front();
                            check("if_rvalid_cycle", cyc, e.due, LAT);
                            check("if_rdata", if_rdata, e.data, LAT);
                            held_if = e.data;
                            $display("lat%0d cycle %0d fetch response data %h", LAT, cyc, if_rdata);
                        end
                    end else begin
                        check("if_rdata_hold", if_rdata, held_if, LAT);
                        if (q_if.size() > 0 && q_if[0].due < cyc) begin
                            check("if_rvalid_missing", 0, 1, LAT);
                            void'(q_if.pop_front());
                        end
                    end
                    if (d_rvalid) begin
                        if (q_d.size() == 0) check("d_rvalid_unexpected", 1, 0, LAT);
                        else begin
                            e = q_d.pop_front();
                            check("d_rvalid_cycle", cyc, e.due, LAT);
                            if (e.store) check("d_rdata_store_hold", d_rdata, held_d, LAT);
                            else begin
                                check("d_rdata", d_rdata, e.data, LAT);
                                held_d = e.data;
                            end
                            $display("lat%0d cycle %0d data response store=%0d data %h",
                                     LAT, cyc, e.store, d_rdata);
                        end
                    end else begin
                        check("d_rdata_hold", d_rdata, held_d, LAT);
                        if (q_d.size() > 0 && q_d[0].due < cyc) begin
                            check("d_rvalid_missing", 0, 1, LAT);
                            void'(q_d.pop_front());
                        end
                    end
                end
            end
        end

        // Requester tasks: called #1 after a rising edge, return #1 after the
        // rising edge that ends the grant cycle.
        task automatic req_if(input logic [11:0] a);
            int n = 0;
            if_req  = 1'b1;
            if_addr = a;
            @(negedge clk);
            while (!if_gnt && n < 300) begin n++; @(negedge clk); end
            if (!if_gnt) check("if_gnt_timeout", 0, 1, LAT);
            @(posedge clk); #1;
            if_req = 1'b0;
        endtask

        task automatic req_d(input logic we, input logic [11:0] a,
                             input logic [31:0] wd, input logic [3:0] be);
            int n = 0;
            d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
            @(negedge clk);
            while (!d_gnt && n < 300) begin n++; @(negedge clk); end
            if (!d_gnt) check("d_gnt_timeout", 0, 1, LAT);
            @(posedge clk); #1;
            d_req = 1'b0;
        endtask

        function automatic logic [11:0] rand_addr();
            return ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 31));
        endfunction

        task automatic gap();
            int k = $urandom_range(0, 2);
            if (k > 0) begin repeat (k) @(posedge clk); #1; end
        endtask

        initial begin
            reset = 1'b1; mem_init = 1'b1;
            if_req = 1'b0; if_addr = '0;
            d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
            repeat (2) @(posedge clk);
            #1 reset = 1'b0; mem_init = 1'b0;
            @(negedge clk);
            check("reset_mem_addr", mem_addr, 0, LAT);
            check("reset_mem_wdata", mem_wdata, 0, LAT);
            check("reset_rdata", {if_rdata, d_rdata}, 0, LAT);
            @(posedge clk); #1;

            // Contention straight after reset: D wins first, then strict alternation.
            fork
                for (int i = 0; i < 4; i++) req_if(12'(4 * i));
                for (int i = 0; i < 4; i++) req_d(1'b0, 12'h010, 32'h0, 4'h0);
            join

            // Instruction word written then fetched.
            req_d(1'b1, 12'h004, 32'h00500093, 4'hF);
            req_if(12'h004);

            // Partial store then load of the merged word.
            req_d(1'b1, 12'h020, 32'hDEADBEEF, 4'b0011);
            req_d(1'b0, 12'h020, 32'h0, 4'h0);

            // Top of the address range.
            req_d(1'b1, 12'hFFF, 32'hA5A5_5A5A, 4'b1100);
            req_d(1'b0, 12'hFFF, 32'h0, 4'h0);

            // Continuous fetch stream.
            for (int i = 0; i < 6; i++) req_if(12'(i));

            // Reset one cycle after a load is granted: load is discarded and a
            // request held across reset is granted right after release.
            repeat (LAT + 1) @(posedge clk); #1;
            req_d(1'b0, 12'h030, 32'h0, 4'h0);
            reset = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 12'h031;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            check("post_reset_d_rdata", d_rdata, 0, LAT);
            check("post_reset_d_gnt", d_gnt, 1, LAT);
            @(posedge clk); #1;
            d_req = 1'b0;

            // Random mixed traffic.
            fork
                for (int i = 0; i < 50; i++) begin
                    gap();
                    req_if(rand_addr());
                end
                for (int i = 0; i < 50; i++) begin
                    gap();
                    req_d(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)));
                end
            join

            repeat (LAT + 4) @(posedge clk);
            check("queues_drained", {16'(q_if.size()), 16'(q_d.size())}, 0, LAT);
            done = 1'b1;
        end
    end

    initial begin
        int t = 0;
        while (!(g_inst[0].done && g_inst[1].done) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 20000) check("global_timeout", 0, 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-port unified memory between the core's instruction-fetch requester and its load/store requester. This lets the RV32I core run from one memory array instead of separate instruction and data memories. The block sits between the core (PC/fetch side and data-memory side) and the memory macro. It arbitrates round-robin, tracks one outstanding transaction with a latency counter, and routes read data back to the owning requester.

## Interface
Parameters:
- ADDR_W, 12, word-address width (4096 words)
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from issue to valid mem_rdata; legal range 1..4

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid this cycle (one-cycle pulse)
- if_rdata  out  DATA_W  fetch data, held until the next if_rvalid
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_be  in  4  store byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid, or store acknowledge (one-cycle pulse)
- d_rdata  out  DATA_W  load data, held until the next load d_rvalid
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write strobe
- mem_be  out  4  byte enables (4'hF on reads)
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after issue

## Operation
- States: IDLE (nothing outstanding) and WAIT (one transaction outstanding; latency counter cnt running; owner flag records IF or D).
- Issue slot: any cycle in IDLE, or the response cycle of WAIT (cnt at its final count).
- In an issue slot, the arbiter selects a requester:
  - one request present → that requester wins;
  - both present → the requester not granted last wins (round-robin; last_owner resets to IF, so the first conflict goes to D).
- On issue:
  - gnt pulses to the winner and mem_en=1, all combinational in the same cycle;
  - mem_addr/mem_we/mem_be/mem_wdata are driven from the winner's inputs;
  - cnt loads MEM_LAT; owner and last_owner update.
- Response cycle:
  - the owner's rvalid=1;
  - for a read, mem_rdata is passed through and captured into the owner's rdata register;
  - for a store, d_rvalid=1 and d_rdata is unchanged.
- Return to IDLE after the response cycle unless a new issue occurs in the same cycle.
- When not issuing, mem_en=0, mem_we=0, mem_be=0, and mem_addr/mem_wdata hold their last values.
- The arbiter never issues a second transaction before the outstanding response. Requests not granted wait with no timeout.
- Address arithmetic: none. Addresses pass through unmodified at ADDR_W bits.

## Timing
- Reset values:
  - if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we = 0
  - mem_be = 0
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0
  - state = IDLE, last_owner = IF
- Latency: issue in cycle N → rvalid in cycle N+MEM_LAT.
- Throughput: one access per MEM_LAT cycles; with MEM_LAT=1, back-to-back issue every cycle.
- A requester may deassert req only after seeing gnt. Changing request fields before gnt is a protocol violation (undefined behaviour).
- A requester may raise a new req in the same cycle its rvalid arrives; it is eligible in that cycle's issue slot.
- Reset asserted mid-transaction: the outstanding transaction is discarded, no rvalid is produced, and all outputs take reset values the next cycle.
- Reset asserted in a cycle with req high: no gnt is given in that cycle.

## Test plan
- Reset then single fetch, MEM_LAT=1: if_addr=0x004, mem holds 0x00500093 → if_gnt cycle 0, mem_en=1, mem_addr=0x004; if_rvalid cycle 1 with if_rdata=0x00500093.
- Simultaneous if_req and d_req (load 0x010) after reset → d_gnt first; if_gnt in the response cycle; strict alternation over 8 contended requests (D, IF, D, IF, …).
- Store d_addr=0x020, d_wdata=0xDEADBEEF, d_be=4'b0011 → mem_we=1, mem_be=4'b0011; d_rvalid pulses and d_rdata is unchanged; a following load of 0x020 returns the memory model's merged word.
- MEM_LAT=3, continuous if_req → if_gnt every 3rd cycle; if_rvalid exactly 3 cycles after each grant; mem_en low in between.
- Reset at cycle 1 of an outstanding MEM_LAT=3 load → no d_rvalid; d_rdata=0; next request is granted immediately after reset release.
